cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 30 +++
 rtl/cpu_sequencer.sv | 158 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the multi-cycle CPU control sequencer:
// FSM states, PC source select codes and one-hot instruction bit positions.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_REG  = 2'd3;

    // R-type ALU ops occupy bits 0-15; I-type ALU ops occupy 17-21 and 26-28.
    localparam int unsigned IDX_ADDU     = 0;
    localparam int unsigned IDX_RTYPE_HI = 15;
    localparam int unsigned IDX_JR       = 16;
    localparam int unsigned IDX_LW       = 22;
    localparam int unsigned IDX_SW       = 23;
    localparam int unsigned IDX_BEQ      = 24;
    localparam int unsigned IDX_BNE      = 25;
    localparam int unsigned IDX_J        = 29;
    localparam int unsigned IDX_JAL      = 30;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: walks FETCH/DECODE/EXEC/MEM/WB from a
// one-hot decoded instruction, with a bounded data-memory wait and a sticky trap.
//
//   state  | meaning
//   FETCH  | load instruction register
//   DECODE | legality check, resolve jumps
//   EXEC   | ALU step, resolve branches
//   MEM    | data-memory access, wait for ack (bounded)
//   WB     | register write-back, advance PC
//   TRAP   | illegal instruction or memory timeout, held until reset
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i,
    input  logic        z,
    input  logic        dm_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_w,
    output logic        dm_cs,
    output logic        dm_r,
    output logic        dm_w,
    output logic [2:0]  state,
    output logic        trap,
    output logic [31:0] instret
);

    localparam int              CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [31:0]      r_instret;
    logic             w_retire;
    logic             w_legal;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    assign w_legal = is_onehot(i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_wait_cnt <= '0;
            r_instret  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_MEM && w_next == ST_MEM) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_SRC_SEQ;
        rf_w     = 1'b0;
        dm_cs    = 1'b0;
        dm_r     = 1'b0;
        dm_w     = 1'b0;
        w_retire = 1'b0;

        case (r_state)
            ST_FETCH: begin
                ir_we  = 1'b1;
                w_next = ST_DECODE;
            end

            ST_DECODE: begin
                if (!w_legal) begin
                    w_next = ST_TRAP;
                end else if (i[IDX_J] || i[IDX_JR]) begin
                    pc_we    = 1'b1;
                    pc_src   = i[IDX_JR] ? PC_SRC_REG : PC_SRC_JUMP;
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end else if (i[IDX_JAL]) begin
                    // jal redirects the PC here but only retires after its link write
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_JUMP;
                    w_next = ST_WB;
                end else begin
                    w_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (i[IDX_BEQ] || i[IDX_BNE]) begin
                    pc_we    = 1'b1;
                    pc_src   = ((i[IDX_BEQ] & z) | (i[IDX_BNE] & ~z)) ? PC_SRC_BR : PC_SRC_SEQ;
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end else if (i[IDX_LW] || i[IDX_SW]) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end

            ST_MEM: begin
                dm_cs = 1'b1;
                dm_r  = i[IDX_LW];
                dm_w  = i[IDX_SW];
                // ack wins over the timeout when both land in the same cycle
                if (dm_ack) begin
                    if (i[IDX_SW]) begin
                        pc_we    = 1'b1;
                        pc_src   = PC_SRC_SEQ;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (r_wait_cnt == CNT_LAST) begin
                    w_next = ST_TRAP;
                end
            end

            ST_WB: begin
                rf_w     = 1'b1;
                w_retire = 1'b1;
                if (!i[IDX_JAL]) begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_SEQ;
                end
                w_next = ST_FETCH;
            end

            ST_TRAP: begin
                w_next = ST_TRAP;
            end

            default: begin
                w_next = ST_TRAP;
            end
        endcase
    end

    assign state   = r_state;
    assign trap    = (r_state == ST_TRAP);
    assign instret = r_instret;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a per-cycle vector table plus
// hand-built memory-wait, timeout and asynchronous-reset sequences.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i;
    logic        z;
    logic        dm_ack;
    logic        ir_we, pc_we, rf_w, dm_cs, dm_r, dm_w, trap;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [31:0] instret;

    cpu_sequencer #(.MEM_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .i(i), .z(z), .dm_ack(dm_ack),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_w(rf_w),
        .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .state(state),
        .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDU = 32'd1 << IDX_ADDU;
    localparam logic [31:0] I_JR   = 32'd1 << IDX_JR;
    localparam logic [31:0] I_LW   = 32'd1 << IDX_LW;
    localparam logic [31:0] I_SW   = 32'd1 << IDX_SW;
    localparam logic [31:0] I_BEQ  = 32'd1 << IDX_BEQ;
    localparam logic [31:0] I_BNE  = 32'd1 << IDX_BNE;
    localparam logic [31:0] I_J    = 32'd1 << IDX_J;
    localparam logic [31:0] I_JAL  = 32'd1 << IDX_JAL;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir;
        logic        pw;
        logic [1:0]  ps;
        logic        rw;
        logic        cs;
        logic        rd;
        logic        wr;
        logic        tr;
        logic [31:0] cnt;
    } out_t;

    typedef struct {
        logic [31:0] vi;
        logic        vz;
        logic        va;
        out_t        exp;
    } vec_t;

    vec_t  vecs[$];
    out_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic out_t eo(input logic [2:0] st, input logic ir, input logic pw,
                                input logic [1:0] ps, input logic rw, input logic cs,
                                input logic rd, input logic wr, input logic tr,
                                input logic [31:0] cnt);
        out_t o;
        o.st = st; o.ir = ir; o.pw = pw; o.ps = ps; o.rw = rw;
        o.cs = cs; o.rd = rd; o.wr = wr; o.tr = tr; o.cnt = cnt;
        return o;
    endfunction

    function automatic out_t o_fetch(input logic [31:0] cnt);
        return eo(ST_FETCH, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    endfunction

    function automatic out_t o_idle(input logic [2:0] st, input logic [31:0] cnt);
        return eo(st, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    endfunction

    function automatic out_t sample();
        out_t o;
        o.st = state; o.ir = ir_we; o.pw = pc_we; o.ps = pc_src; o.rw = rf_w;
        o.cs = dm_cs; o.rd = dm_r; o.wr = dm_w; o.tr = trap; o.cnt = instret;
        return o;
    endfunction

    task automatic add(input logic [31:0] vi, input logic vz, input logic va, input out_t e);
        vec_t v;
        v.vi = vi; v.vz = vz; v.va = va; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input string nm, input out_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_pop();
        out_t  e, a;
        string nm;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = sample();
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got st=%0d ir=%0b pw=%0b ps=%0d rw=%0b cs=%0b rd=%0b wr=%0b tr=%0b instret=%0d; expected st=%0d ir=%0b pw=%0b ps=%0d rw=%0b cs=%0b rd=%0b wr=%0b tr=%0b instret=%0d",
                     nm, a.st, a.ir, a.pw, a.ps, a.rw, a.cs, a.rd, a.wr, a.tr, a.cnt,
                     e.st, e.ir, e.pw, e.ps, e.rw, e.cs, e.rd, e.wr, e.tr, e.cnt);
        end
    endtask

    // Called 1 time unit after a rising edge; leaves the bench at the same phase.
    task automatic step(input string nm, input logic [31:0] vi, input logic vz,
                        input logic va, input out_t e);
        i = vi; z = vz; dm_ack = va;
        push_exp(nm, e);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; i = 32'd0; z = 1'b0; dm_ack = 1'b0;
        #1 rst = 1'b1;
        #2;
        push_exp("reset_values", o_fetch(32'd0));
        check_pop();
        @(posedge clk);
        #1 rst = 1'b0;

        // addu: FETCH, DECODE, EXEC, WB
        add(I_ADDU, 0, 0, o_fetch(0));
        add(I_ADDU, 0, 0, o_idle(ST_DECODE, 0));
        add(I_ADDU, 0, 0, o_idle(ST_EXEC, 0));
        add(I_ADDU, 0, 0, eo(ST_WB, 0, 1, PC_SRC_SEQ, 1, 0, 0, 0, 0, 0));
        // lw: stray acks before MEM are ignored, ack on the third MEM cycle
        add(I_LW, 0, 1, o_fetch(1));
        add(I_LW, 0, 1, o_idle(ST_DECODE, 1));
        add(I_LW, 0, 1, o_idle(ST_EXEC, 1));
        add(I_LW, 0, 0, eo(ST_MEM, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        add(I_LW, 0, 0, eo(ST_MEM, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        add(I_LW, 0, 1, eo(ST_MEM, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        add(I_LW, 0, 0, eo(ST_WB, 0, 1, PC_SRC_SEQ, 1, 0, 0, 0, 0, 1));
        // beq taken, then not taken
        add(I_BEQ, 0, 0, o_fetch(2));
        add(I_BEQ, 0, 0, o_idle(ST_DECODE, 2));
        add(I_BEQ, 1, 0, eo(ST_EXEC, 0, 1, PC_SRC_BR, 0, 0, 0, 0, 0, 2));
        add(I_BEQ, 1, 0, o_fetch(3));
        add(I_BEQ, 1, 0, o_idle(ST_DECODE, 3));
        add(I_BEQ, 0, 0, eo(ST_EXEC, 0, 1, PC_SRC_SEQ, 0, 0, 0, 0, 0, 3));
        // sw acked on first MEM cycle
        add(I_SW, 0, 0, o_fetch(4));
        add(I_SW, 0, 0, o_idle(ST_DECODE, 4));
        add(I_SW, 0, 0, o_idle(ST_EXEC, 4));
        add(I_SW, 0, 1, eo(ST_MEM, 0, 1, PC_SRC_SEQ, 0, 1, 0, 1, 0, 4));
        // j, jr
        add(I_J, 0, 0, o_fetch(5));
        add(I_J, 0, 0, eo(ST_DECODE, 0, 1, PC_SRC_JUMP, 0, 0, 0, 0, 0, 5));
        add(I_JR, 0, 0, o_fetch(6));
        add(I_JR, 0, 0, eo(ST_DECODE, 0, 1, PC_SRC_REG, 0, 0, 0, 0, 0, 6));
        // jal: pc_we in DECODE without retiring, link write in WB retires it
        add(I_JAL, 0, 0, o_fetch(7));
        add(I_JAL, 0, 0, eo(ST_DECODE, 0, 1, PC_SRC_JUMP, 0, 0, 0, 0, 0, 7));
        add(I_JAL, 0, 0, eo(ST_WB, 0, 0, 2'd0, 1, 0, 0, 0, 0, 7));
        // bne taken, then not taken
        add(I_BNE, 1, 0, o_fetch(8));
        add(I_BNE, 1, 0, o_idle(ST_DECODE, 8));
        add(I_BNE, 0, 0, eo(ST_EXEC, 0, 1, PC_SRC_BR, 0, 0, 0, 0, 0, 8));
        add(I_BNE, 0, 0, o_fetch(9));
        add(I_BNE, 0, 0, o_idle(ST_DECODE, 9));
        add(I_BNE, 1, 0, eo(ST_EXEC, 0, 1, PC_SRC_SEQ, 0, 0, 0, 0, 0, 9));
        // two bits set: trap, sticky, instret frozen
        add(32'h3, 0, 0, o_fetch(10));
        add(32'h3, 0, 0, o_idle(ST_DECODE, 10));
        add(32'h3, 0, 0, eo(ST_TRAP, 0, 0, 0, 0, 0, 0, 0, 1, 10));
        add(I_LW, 1, 1, eo(ST_TRAP, 0, 0, 0, 0, 0, 0, 0, 1, 10));

        for (int k = 0; k < vecs.size(); k++) begin
            step($sformatf("vec%0d", k), vecs[k].vi, vecs[k].vz, vecs[k].va, vecs[k].exp);
        end

        // lw whose ack lands on the last permitted MEM cycle
        do_reset();
        step("lw_lim_fetch", I_LW, 0, 0, o_fetch(0));
        step("lw_lim_decode", I_LW, 0, 0, o_idle(ST_DECODE, 0));
        step("lw_lim_exec", I_LW, 0, 0, o_idle(ST_EXEC, 0));
        for (int k = 0; k < 254; k++) begin
            step($sformatf("lw_lim_mem%0d", k), I_LW, 0, 0, eo(ST_MEM, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        end
        step("lw_lim_mem_ack", I_LW, 0, 1, eo(ST_MEM, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        step("lw_lim_wb", I_LW, 0, 0, eo(ST_WB, 0, 1, PC_SRC_SEQ, 1, 0, 0, 0, 0, 0));
        step("lw_lim_next_fetch", I_LW, 0, 0, o_fetch(1));

        // asynchronous reset in the middle of a MEM wait
        step("mid_decode", I_LW, 0, 0, o_idle(ST_DECODE, 1));
        step("mid_exec", I_LW, 0, 0, o_idle(ST_EXEC, 1));
        step("mid_mem0", I_LW, 0, 0, eo(ST_MEM, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        i = I_LW; z = 1'b0; dm_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        push_exp("async_rst_mid_mem", o_fetch(0));
        check_pop();
        @(posedge clk);
        #1 rst = 1'b0;

        // sw never acked: 255 MEM cycles then trap
        step("to_fetch", I_SW, 0, 0, o_fetch(0));
        step("to_decode", I_SW, 0, 0, o_idle(ST_DECODE, 0));
        step("to_exec", I_SW, 0, 0, o_idle(ST_EXEC, 0));
        for (int k = 0; k < 255; k++) begin
            step($sformatf("to_mem%0d", k), I_SW, 0, 0, eo(ST_MEM, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        end
        step("to_trap", I_SW, 0, 0, eo(ST_TRAP, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step("to_trap_late_ack", I_SW, 0, 1, eo(ST_TRAP, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        // zero instruction word traps
        do_reset();
        step("zero_fetch", 32'd0, 0, 0, o_fetch(0));
        step("zero_decode", 32'd0, 0, 0, o_idle(ST_DECODE, 0));
        step("zero_trap", 32'd0, 0, 0, eo(ST_TRAP, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
